// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares the SDRAM controller host port among NPORTS requesters.
// One op is owned at a time. It is latched in IDLE, driven to the controller
// in ISSUE until the controller reports op_begun, then waits in BUSY for done.
// begun, done and read data are steered back to the owning port.
//
// Ports:
//   clk_i, rst_bi             clock, async active-low reset
//   req_rd_i/req_wr_i         per-port requests, held until req_begun_o
//   req_addr_i/req_data_i     per-port addr/data, port n at [n*W +: W]
//   req_begun_o               comb pulse while the controller accepts the owner's op
//   req_done_o/req_rd_done_o  registered pulses to the owner
//   req_data_o                captured read data, held until the next capture
//   grant_o, busy_o           current owner (one-hot), ISSUE/BUSY indicator
//   ctrl_*                    controller host interface
module sdram_arbiter #(
  parameter int    NPORTS      = 2,
  parameter int    HADDR_WIDTH = 23,
  parameter int    DATA_WIDTH  = 16,
  parameter string FIXED_PRIO  = "FALSE"
) (
  input  logic                          clk_i,
  input  logic                          rst_bi,
  input  logic [NPORTS-1:0]             req_rd_i,
  input  logic [NPORTS-1:0]             req_wr_i,
  input  logic [NPORTS*HADDR_WIDTH-1:0] req_addr_i,
  input  logic [NPORTS*DATA_WIDTH-1:0]  req_data_i,
  output logic [NPORTS-1:0]             req_begun_o,
  output logic [NPORTS-1:0]             req_done_o,
  output logic [NPORTS-1:0]             req_rd_done_o,
  output logic [DATA_WIDTH-1:0]         req_data_o,
  output logic [NPORTS-1:0]             grant_o,
  output logic                          busy_o,
  output logic                          ctrl_rd_o,
  output logic                          ctrl_wr_o,
  output logic [HADDR_WIDTH-1:0]        ctrl_addr_o,
  output logic [DATA_WIDTH-1:0]         ctrl_data_o,
  input  logic                          ctrl_op_begun_i,
  input  logic                          ctrl_done_i,
  input  logic                          ctrl_rd_done_i,
  input  logic [DATA_WIDTH-1:0]         ctrl_data_i
);

  localparam int PW    = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam bit FIXED = (FIXED_PRIO == "TRUE");

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;

  state_t                  state, state_nxt;
  logic [PW-1:0]           last_grant;
  logic [NPORTS-1:0]       pend, pend_sh, rd_sh, wr_sh;
  int                      cand, win_int;
  logic                    win_vld, win_rd, win_wr;
  logic [HADDR_WIDTH-1:0]  win_addr;
  logic [DATA_WIDTH-1:0]   win_data;
  logic                    fin;

  assign pend = req_rd_i | req_wr_i;

  // Walk candidates from lowest to highest priority so the last hit is the
  // winner. Round-robin rank 0 is the port just after last_grant.
  always_comb begin
    cand    = 0;
    win_int = 0;
    win_vld = 1'b0;
    pend_sh = '0;
    for (int k = NPORTS - 1; k >= 0; k--) begin
      cand = FIXED ? k : int'(last_grant) + 1 + k;
      if (cand >= NPORTS) cand = cand - NPORTS;
      pend_sh = pend >> cand;
      if (pend_sh[0]) begin
        win_int = cand;
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    rd_sh    = req_rd_i >> win_int;
    wr_sh    = req_wr_i >> win_int;
    win_rd   = rd_sh[0];
    win_wr   = wr_sh[0] & ~rd_sh[0];  // read wins when both are asserted
    win_addr = req_addr_i[win_int*HADDR_WIDTH +: HADDR_WIDTH];
    win_data = req_data_i[win_int*DATA_WIDTH +: DATA_WIDTH];
  end

  // Op finishes either from BUSY or directly from ISSUE when begun and done coincide.
  assign fin = ctrl_done_i & ((state == BUSY) | ((state == ISSUE) & ctrl_op_begun_i));

  // state register
  always_ff @(posedge clk_i or negedge rst_bi) begin
    if (!rst_bi) state <= IDLE;
    else         state <= state_nxt;
  end

  // next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_vld) state_nxt = ISSUE;
      ISSUE:   if (ctrl_op_begun_i) state_nxt = ctrl_done_i ? IDLE : BUSY;
      BUSY:    if (ctrl_done_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // outputs decoded from state
  always_comb begin
    busy_o      = (state != IDLE);
    req_begun_o = ((state == ISSUE) && ctrl_op_begun_i) ? grant_o : '0;
  end

  // latched command, ownership and return-path pulses
  always_ff @(posedge clk_i or negedge rst_bi) begin
    if (!rst_bi) begin
      last_grant    <= PW'(NPORTS - 1);
      grant_o       <= '0;
      ctrl_rd_o     <= 1'b0;
      ctrl_wr_o     <= 1'b0;
      ctrl_addr_o   <= '0;
      ctrl_data_o   <= '0;
      req_done_o    <= '0;
      req_rd_done_o <= '0;
      req_data_o    <= '0;
    end else begin
      req_done_o    <= fin ? grant_o : '0;
      req_rd_done_o <= '0;
      if (state != IDLE && ctrl_rd_done_i) begin
        req_data_o    <= ctrl_data_i;
        req_rd_done_o <= grant_o;
      end
      if (state == IDLE && win_vld) begin
        grant_o     <= {{(NPORTS-1){1'b0}}, 1'b1} << win_int;
        last_grant  <= PW'(win_int);
        ctrl_rd_o   <= win_rd;
        ctrl_wr_o   <= win_wr;
        ctrl_addr_o <= win_addr;
        ctrl_data_o <= win_data;
      end else begin
        if (state == ISSUE && ctrl_op_begun_i) begin
          ctrl_rd_o <= 1'b0;
          ctrl_wr_o <= 1'b0;
        end
        if (fin) grant_o <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: a per-cycle vector table for single ops and the
// begun+done-same-cycle case, then hand sequences for round-robin vs fixed
// priority and reset in the middle of an op.
module tb_sdram_arbiter;

  logic        clk = 1'b0;
  logic        rst_bi = 1'b0;
  logic [1:0]  req_rd = '0, req_wr = '0;
  logic [22:0] a0 = '0, a1 = '0;
  logic [15:0] d0 = '0, d1 = '0;
  logic        begun = 1'b0, done = 1'b0, rdd = 1'b0;
  logic [15:0] din = '0;

  logic [1:0]  req_begun, req_done, req_rd_done, grant;
  logic [15:0] req_data, ctrl_data;
  logic        busy, ctrl_rd, ctrl_wr;
  logic [22:0] ctrl_addr;

  logic [1:0]  f_begun, f_done, f_rd_done, f_grant;
  logic [15:0] f_data, f_ctrl_data;
  logic        f_busy, f_ctrl_rd, f_ctrl_wr;
  logic [22:0] f_ctrl_addr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sdram_arbiter #(.NPORTS(2), .HADDR_WIDTH(23), .DATA_WIDTH(16), .FIXED_PRIO("FALSE")) dut (
    .clk_i(clk), .rst_bi(rst_bi), .req_rd_i(req_rd), .req_wr_i(req_wr),
    .req_addr_i({a1, a0}), .req_data_i({d1, d0}),
    .req_begun_o(req_begun), .req_done_o(req_done), .req_rd_done_o(req_rd_done),
    .req_data_o(req_data), .grant_o(grant), .busy_o(busy),
    .ctrl_rd_o(ctrl_rd), .ctrl_wr_o(ctrl_wr), .ctrl_addr_o(ctrl_addr), .ctrl_data_o(ctrl_data),
    .ctrl_op_begun_i(begun), .ctrl_done_i(done), .ctrl_rd_done_i(rdd), .ctrl_data_i(din));

  sdram_arbiter #(.NPORTS(2), .HADDR_WIDTH(23), .DATA_WIDTH(16), .FIXED_PRIO("TRUE")) dut_fp (
    .clk_i(clk), .rst_bi(rst_bi), .req_rd_i(req_rd), .req_wr_i(req_wr),
    .req_addr_i({a1, a0}), .req_data_i({d1, d0}),
    .req_begun_o(f_begun), .req_done_o(f_done), .req_rd_done_o(f_rd_done),
    .req_data_o(f_data), .grant_o(f_grant), .busy_o(f_busy),
    .ctrl_rd_o(f_ctrl_rd), .ctrl_wr_o(f_ctrl_wr), .ctrl_addr_o(f_ctrl_addr), .ctrl_data_o(f_ctrl_data),
    .ctrl_op_begun_i(begun), .ctrl_done_i(done), .ctrl_rd_done_i(rdd), .ctrl_data_i(din));

  typedef struct {
    logic [1:0]  rd, wr;
    logic [22:0] a0, a1;
    logic        bg, dn, rdd;
    logic [15:0] din;
    logic [1:0]  e_g;
    logic        e_rd, e_wr;
    logic [22:0] e_addr;
    logic        e_busy;
    logic [1:0]  e_bg, e_dn, e_rdd;
    logic [15:0] e_dout;
  } vec_t;

  vec_t vt [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Waits (bounded) for the RR instance to own an op, then drives begun and
  // done on consecutive cycles. Returns at the negedge of the cycle after done.
  task automatic op(output logic [1:0] g, output logic [1:0] gf, output int n);
    n = 0;
    while (!busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("op wait busy", 32'(busy), 32'd1);
    g  = grant;
    gf = f_grant;
    begun = 1'b1;
    #1 chk("op begun pulse", 32'(req_begun), 32'(g));
    @(negedge clk);
    begun = 1'b0;
    done  = 1'b1;
    @(negedge clk);
    done = 1'b0;
    chk("op done pulse", 32'(req_done), 32'(g));
    chk("op idle after done", 32'({busy, grant}), 32'd0);
  endtask

  initial begin
    logic [1:0] g, gf;
    int n;
    logic [1:0] rr_exp [4];
    rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01; rr_exp[3] = 2'b10;

    //        rd     wr     a0        a1         bg    dn    rdd   din       e_g    e_rd  e_wr  e_addr     e_busy e_bg   e_dn   e_rdd  e_dout
    vt[0]  = '{2'b01, 2'b00, 23'h123, 23'h0,      1'b0, 1'b0, 1'b0, 16'h0,    2'b00, 1'b0, 1'b0, 23'h0,      1'b0, 2'b00, 2'b00, 2'b00, 16'h0};
    vt[1]  = '{2'b01, 2'b00, 23'h123, 23'h0,      1'b0, 1'b0, 1'b0, 16'h0,    2'b01, 1'b1, 1'b0, 23'h123,    1'b1, 2'b00, 2'b00, 2'b00, 16'h0};
    vt[2]  = '{2'b01, 2'b00, 23'h123, 23'h0,      1'b1, 1'b0, 1'b0, 16'h0,    2'b01, 1'b1, 1'b0, 23'h123,    1'b1, 2'b01, 2'b00, 2'b00, 16'h0};
    vt[3]  = '{2'b00, 2'b00, 23'h123, 23'h0,      1'b0, 1'b0, 1'b1, 16'hBEEF, 2'b01, 1'b0, 1'b0, 23'h123,    1'b1, 2'b00, 2'b00, 2'b00, 16'h0};
    vt[4]  = '{2'b00, 2'b00, 23'h123, 23'h0,      1'b0, 1'b1, 1'b0, 16'h0,    2'b01, 1'b0, 1'b0, 23'h123,    1'b1, 2'b00, 2'b00, 2'b01, 16'hBEEF};
    vt[5]  = '{2'b00, 2'b00, 23'h123, 23'h0,      1'b0, 1'b0, 1'b0, 16'h0,    2'b00, 1'b0, 1'b0, 23'h123,    1'b0, 2'b00, 2'b01, 2'b00, 16'hBEEF};
    // done / rd_done while idle must be ignored
    vt[6]  = '{2'b00, 2'b00, 23'h123, 23'h0,      1'b0, 1'b1, 1'b1, 16'hFFFF, 2'b00, 1'b0, 1'b0, 23'h123,    1'b0, 2'b00, 2'b00, 2'b00, 16'hBEEF};
    // port 1 rd+wr together: read wins; begun and done in the same cycle
    vt[7]  = '{2'b10, 2'b10, 23'h0,   23'h7FFFFF, 1'b0, 1'b0, 1'b0, 16'h0,    2'b00, 1'b0, 1'b0, 23'h123,    1'b0, 2'b00, 2'b00, 2'b00, 16'hBEEF};
    vt[8]  = '{2'b10, 2'b10, 23'h0,   23'h7FFFFF, 1'b1, 1'b1, 1'b0, 16'h0,    2'b10, 1'b1, 1'b0, 23'h7FFFFF, 1'b1, 2'b10, 2'b00, 2'b00, 16'hBEEF};
    vt[9]  = '{2'b00, 2'b00, 23'h0,   23'h7FFFFF, 1'b0, 1'b0, 1'b0, 16'h0,    2'b00, 1'b0, 1'b0, 23'h7FFFFF, 1'b0, 2'b00, 2'b10, 2'b00, 16'hBEEF};
    vt[10] = '{2'b00, 2'b00, 23'h0,   23'h7FFFFF, 1'b0, 1'b0, 1'b0, 16'h0,    2'b00, 1'b0, 1'b0, 23'h7FFFFF, 1'b0, 2'b00, 2'b00, 2'b00, 16'hBEEF};

    // reset state
    @(negedge clk);
    #1;
    chk("reset grant", 32'(grant), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset ctrl rd/wr", 32'({ctrl_rd, ctrl_wr}), 32'd0);
    chk("reset ctrl addr", 32'(ctrl_addr), 32'd0);
    chk("reset pulses", 32'({req_begun, req_done, req_rd_done}), 32'd0);
    chk("reset req data", 32'(req_data), 32'd0);
    @(negedge clk);
    rst_bi = 1'b1;

    for (int i = 0; i < 11; i++) begin
      req_rd = vt[i].rd;  req_wr = vt[i].wr;
      a0 = vt[i].a0;      a1 = vt[i].a1;
      begun = vt[i].bg;   done = vt[i].dn;  rdd = vt[i].rdd;  din = vt[i].din;
      #1;
      chk($sformatf("v%0d grant", i),     32'(grant),       32'(vt[i].e_g));
      chk($sformatf("v%0d ctrl_rd", i),   32'(ctrl_rd),     32'(vt[i].e_rd));
      chk($sformatf("v%0d ctrl_wr", i),   32'(ctrl_wr),     32'(vt[i].e_wr));
      chk($sformatf("v%0d ctrl_addr", i), 32'(ctrl_addr),   32'(vt[i].e_addr));
      chk($sformatf("v%0d busy", i),      32'(busy),        32'(vt[i].e_busy));
      chk($sformatf("v%0d begun", i),     32'(req_begun),   32'(vt[i].e_bg));
      chk($sformatf("v%0d done", i),      32'(req_done),    32'(vt[i].e_dn));
      chk($sformatf("v%0d rd_done", i),   32'(req_rd_done), 32'(vt[i].e_rdd));
      chk($sformatf("v%0d req_data", i),  32'(req_data),    32'(vt[i].e_dout));
      @(negedge clk);
    end
    begun = 1'b0; done = 1'b0; rdd = 1'b0;

    // both ports continuous: RR alternates, fixed priority keeps port 0
    rst_bi = 1'b0;
    @(negedge clk);
    rst_bi = 1'b1;
    req_rd = 2'b11; a0 = 23'h1; a1 = 23'h2;
    for (int i = 0; i < 4; i++) begin
      op(g, gf, n);
      chk($sformatf("rr op%0d grant", i), 32'(g), 32'(rr_exp[i]));
      chk($sformatf("fp op%0d grant", i), 32'(gf), 32'd1);
      chk($sformatf("op%0d grant latency", i), 32'(n), 32'd1);
    end
    req_rd = 2'b10;
    op(g, gf, n);
    chk("rr port1 only grant", 32'(g), 32'd2);
    chk("fp port1 after port0 drops", 32'(gf), 32'd2);
    req_rd = 2'b00;
    @(negedge clk);

    // reset while BUSY drops the op silently
    req_wr = 2'b10; a1 = 23'hABCD; d1 = 16'h1234;
    @(negedge clk);
    chk("rst seq issue", 32'({busy, ctrl_wr}), 32'd3);
    begun = 1'b1;
    @(negedge clk);
    begun = 1'b0; req_wr = 2'b00;
    chk("rst seq busy", 32'({busy, ctrl_wr}), 32'd2);
    rst_bi = 1'b0;
    #1;
    chk("mid-op reset grant/busy", 32'({grant, busy}), 32'd0);
    chk("mid-op reset ctrl", 32'({ctrl_rd, ctrl_wr}), 32'd0);
    chk("mid-op reset addr", 32'(ctrl_addr), 32'd0);
    chk("mid-op reset data", 32'(ctrl_data), 32'd0);
    chk("mid-op reset pulses", 32'({req_begun, req_done, req_rd_done}), 32'd0);
    @(negedge clk);
    rst_bi = 1'b1;
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    chk("no done for dropped op", 32'(req_done), 32'd0);
    req_wr = 2'b10; a1 = 23'h55; d1 = 16'h5A5A;
    @(negedge clk);
    chk("post-reset grant", 32'(grant), 32'd2);
    chk("post-reset ctrl rd/wr", 32'({ctrl_rd, ctrl_wr}), 32'd1);
    chk("post-reset addr", 32'(ctrl_addr), 32'h55);
    chk("post-reset data", 32'(ctrl_data), 32'h5A5A);
    begun = 1'b1;
    @(negedge clk);
    begun = 1'b0; req_wr = 2'b00; done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    chk("post-reset done", 32'(req_done), 32'd2);
    chk("post-reset fp done", 32'(f_done), 32'd2);
    @(negedge clk);
    chk("post-reset done single", 32'(req_done), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
